fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/fetch_ctrl_if.sv | 33 +++
 rtl/fetch_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the sequential PC step.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REDIR  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Targets are word aligned; the low two bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage signal bundle between fetch_ctrl and the datapath.
// Counter signals exist only when FETCH_CNT_EN is defined.
interface fetch_ctrl_if;

    logic                  ihit;
    logic                  stall;
    logic                  redirect;
    cpu_types_pkg::word_t  rtarget;
    logic                  halt;
    logic                  imemREN;
    cpu_types_pkg::word_t  imemaddr;
    cpu_types_pkg::word_t  pc;
    cpu_types_pkg::word_t  npc;
    logic                  PCen;
    logic                  ivalid;
`ifdef FETCH_CNT_EN
    cpu_types_pkg::word_t  fetch_cnt;
    cpu_types_pkg::word_t  wait_cnt;
`endif

`ifdef FETCH_CNT_EN
    modport fc (input ihit, stall, redirect, rtarget, halt,
                output imemREN, imemaddr, pc, npc, PCen, ivalid, fetch_cnt, wait_cnt);
    modport tb (output ihit, stall, redirect, rtarget, halt,
                input imemREN, imemaddr, pc, npc, PCen, ivalid, fetch_cnt, wait_cnt);
`else
    modport fc (input ihit, stall, redirect, rtarget, halt,
                output imemREN, imemaddr, pc, npc, PCen, ivalid);
    modport tb (output ihit, stall, redirect, rtarget, halt,
                input imemREN, imemaddr, pc, npc, PCen, ivalid);
`endif

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirect while a read is pending, halt.
// Optional FETCH_CNT_EN adds fetch/wait performance counters.
module fetch_ctrl
    import cpu_types_pkg::*;
#(
    parameter word_t PC_RESET = 32'h00000000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  logic  stall,
    input  logic  redirect,
    input  word_t rtarget,
    input  logic  halt,
    output logic  imemREN,
    output word_t imemaddr,
    output word_t pc,
    output word_t npc,
    output logic  PCen,
    output logic  ivalid
`ifdef FETCH_CNT_EN
    ,
    output word_t fetch_cnt,
    output word_t wait_cnt
`endif
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    word_t        tgt_q;
    word_t        tgt_nxt;
    word_t        pc_nxt;
    logic         ivalid_c;

    // Next PC / state / saved target; halt outranks everything else.
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_q;
        pc_nxt    = pc;
        ivalid_c  = 1'b0;
        if (halt) begin
            state_nxt = HALTED;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        if (ihit) begin
                            pc_nxt = align_word(rtarget);
                        end else begin
                            // Let the outstanding read finish before moving pc.
                            tgt_nxt   = align_word(rtarget);
                            state_nxt = REDIR;
                        end
                    end else if (ihit && !stall) begin
                        ivalid_c = 1'b1;
                        pc_nxt   = pc + PC_STEP;
                    end
                end
                REDIR: begin
                    if (redirect) begin
                        tgt_nxt = align_word(rtarget);
                    end
                    if (ihit) begin
                        pc_nxt    = redirect ? align_word(rtarget) : tgt_q;
                        state_nxt = RUN;
                    end
                end
                HALTED: begin
                    state_nxt = HALTED;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
            pc    <= PC_RESET;
            tgt_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            tgt_q <= tgt_nxt;
        end
    end

    assign imemREN  = (state != HALTED);
    assign imemaddr = pc;
    assign npc      = pc + PC_STEP;
    assign ivalid   = ivalid_c & nRST;
    assign PCen     = (pc_nxt != pc) & nRST;

`ifdef FETCH_CNT_EN
    // Both counters freeze once halted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt <= '0;
            wait_cnt  <= '0;
        end else if (state != HALTED) begin
            if (ivalid) begin
                fetch_cnt <= fetch_cnt + word_t'(1);
            end
            if (imemREN && !ihit) begin
                wait_cnt <= wait_cnt + word_t'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios then randomized traffic.
// Counter checks are enabled when FETCH_CNT_EN is defined.
module tb_fetch_ctrl;
    import cpu_types_pkg::*;

    localparam word_t RST_PC = 32'h00000000;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    fetch_ctrl_if bus ();

    always #5 CLK = ~CLK;

    fetch_ctrl #(.PC_RESET(RST_PC)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ihit     (bus.ihit),
        .stall    (bus.stall),
        .redirect (bus.redirect),
        .rtarget  (bus.rtarget),
        .halt     (bus.halt),
        .imemREN  (bus.imemREN),
        .imemaddr (bus.imemaddr),
        .pc       (bus.pc),
        .npc      (bus.npc),
        .PCen     (bus.PCen),
        .ivalid   (bus.ivalid)
`ifdef FETCH_CNT_EN
        ,
        .fetch_cnt(bus.fetch_cnt),
        .wait_cnt (bus.wait_cnt)
`endif
    );

    typedef struct {
        word_t pc;
        logic  ivalid;
        logic  pcen;
        logic  ren;
        word_t fc;
        word_t wc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: architectural PC, pending redirect, halted flag.
    word_t m_pc;
    word_t m_tgt;
    bit    m_pend;
    bit    m_halt;
    word_t m_fc;
    word_t m_wc;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and queue the outputs the model predicts for it.
    task automatic step(input bit rst_n, input bit ih, input bit st, input bit rd,
                        input word_t tg, input bit hl);
        exp_t  e;
        word_t next_pc;
        word_t aligned;
        bit    v;
        @(posedge CLK);
        #1;
        nRST         = rst_n;
        bus.ihit     = ih;
        bus.stall    = st;
        bus.redirect = rd;
        bus.rtarget  = tg;
        bus.halt     = hl;
        if (!rst_n) begin
            m_pc = RST_PC; m_tgt = '0; m_pend = 0; m_halt = 0; m_fc = '0; m_wc = '0;
            e.pc = RST_PC; e.ivalid = 0; e.pcen = 0; e.ren = 1; e.fc = '0; e.wc = '0;
            q.push_back(e);
            return;
        end
        aligned = tg & 32'hFFFF_FFFC;
        next_pc = m_pc;
        v       = 0;
        e.pc  = m_pc;
        e.ren = !m_halt;
        e.fc  = m_fc;
        e.wc  = m_wc;
        if (!m_halt) begin
            if (!ih) m_wc = m_wc + 1;
            if (hl) begin
                m_halt = 1;
            end else if (m_pend) begin
                if (rd) m_tgt = aligned;
                if (ih) begin
                    next_pc = m_tgt;
                    m_pend  = 0;
                end
            end else if (rd) begin
                if (ih) next_pc = aligned;
                else begin
                    m_tgt  = aligned;
                    m_pend = 1;
                end
            end else if (ih && !st) begin
                v       = 1;
                next_pc = m_pc + 4;
            end
            if (v) m_fc = m_fc + 1;
        end
        e.ivalid = v;
        e.pcen   = (next_pc != m_pc);
        m_pc     = next_pc;
        q.push_back(e);
    endtask

    // Monitor: pop the prediction for each cycle and compare mid-cycle.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc",       bus.pc,       e.pc);
            chk("imemaddr", bus.imemaddr, e.pc);
            chk("npc",      bus.npc,      e.pc + 32'd4);
            chk("ivalid",   32'(bus.ivalid),  32'(e.ivalid));
            chk("PCen",     32'(bus.PCen),    32'(e.pcen));
            chk("imemREN",  32'(bus.imemREN), 32'(e.ren));
`ifdef FETCH_CNT_EN
            chk("fetch_cnt", bus.fetch_cnt, e.fc);
            chk("wait_cnt",  bus.wait_cnt,  e.wc);
`endif
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit ih, st, rd, hl;
        bus.ihit = 0; bus.stall = 0; bus.redirect = 0; bus.rtarget = '0; bus.halt = 0;
        step(0, 0, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        // Sequential fetch 0 -> 4 -> 8 -> C.
        repeat (3) step(1, 1, 0, 0, '0, 0);
        // Stall holds pc with ihit present.
        repeat (2) step(1, 1, 1, 0, '0, 0);
        // Redirect during a miss, overwritten by a later redirect.
        step(1, 0, 0, 1, 32'h0000_0103, 0);
        step(1, 0, 0, 1, 32'h0000_0200, 0);
        step(1, 1, 0, 0, '0, 0);
        // Redirect with hit outranks stall.
        step(1, 1, 1, 1, 32'h0000_0040, 0);
        step(1, 0, 0, 0, '0, 0);
        // Wrap at top of address space, then halt and confirm it is sticky.
        step(1, 1, 0, 1, 32'hFFFF_FFFC, 0);
        step(1, 1, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 1);
        step(1, 1, 0, 1, 32'h0000_0080, 0);
        step(1, 1, 0, 0, '0, 0);
        step(1, 0, 0, 1, 32'h0000_0300, 0);
        // Reset mid-REDIR drops the saved target.
        step(0, 0, 0, 0, '0, 0);
        step(1, 0, 0, 1, 32'h0000_0500, 0);
        step(0, 0, 0, 0, '0, 0);
        step(1, 1, 0, 0, '0, 0);
        step(1, 1, 0, 0, '0, 0);
        // Five fetches interleaved with three miss cycles from reset.
        step(0, 0, 0, 0, '0, 0);
        step(1, 1, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        step(1, 1, 0, 0, '0, 0);
        step(1, 1, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        step(1, 1, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        step(1, 1, 0, 0, '0, 0);
        step(1, 1, 1, 0, '0, 0);
        @(negedge CLK);
        #1;
`ifdef FETCH_CNT_EN
        chk("fetch_cnt_five", bus.fetch_cnt, 32'd5);
        chk("wait_cnt_three", bus.wait_cnt,  32'd3);
`endif
        chk("pc_after_five", bus.pc, RST_PC + 32'd20);
        // Randomized traffic with occasional halt and recovery by reset.
        for (int i = 0; i < 400; i++) begin
            if (m_halt && $urandom_range(0, 7) == 0) begin
                step(0, 0, 0, 0, '0, 0);
            end else begin
                ih = ($urandom_range(0, 3) != 0);
                st = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 5) == 0);
                hl = ($urandom_range(0, 79) == 0);
                step(1, ih, st, rd, $urandom, hl);
            end
        end
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
